// File: rtl/fwd_pkg.sv
// Shared constants and history-slot type for the EX-stage forwarding control.
package fwd_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned SEL_W      = 2;

    localparam logic [SEL_W-1:0] FWD_REG     = 2'b00;
    localparam logic [SEL_W-1:0] FWD_BEFORE1 = 2'b10;
    localparam logic [SEL_W-1:0] FWD_BEFORE2 = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  load;
    } fwd_slot_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational forwarding select and load-use detection for one source operand.
// With FWD_R0_ZERO_EN defined, register 0 never matches a producer.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  src_used_i,
    input  fwd_slot_t             slot1_i,
    input  fwd_slot_t             slot2_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  load_hit_o
);

    logic src_fwd_ok;
    logic match1;
    logic match2;
    logic unused_slot2_load;

`ifdef FWD_R0_ZERO_EN
    assign src_fwd_ok = (src_i != '0);
`else
    assign src_fwd_ok = 1'b1;
`endif

    assign match1 = src_used_i & src_fwd_ok & slot1_i.valid & slot1_i.we &
                    (slot1_i.rd == src_i);
    assign match2 = src_used_i & src_fwd_ok & slot2_i.valid & slot2_i.we &
                    (slot2_i.rd == src_i);

    // A load in slot2 has its data ready, so only slot1 can raise a hazard.
    assign load_hit_o        = match1 & slot1_i.load;
    assign unused_slot2_load = slot2_i.load;

    always_comb begin
        sel_o = FWD_REG;
        if (match1) begin
            sel_o = FWD_BEFORE1;
        end else if (match2) begin
            sel_o = FWD_BEFORE2;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Operand-forwarding select generator with load-use stall for the 16-bit pipeline.
// Optional r0-hardwired-zero behaviour is enabled by defining FWD_R0_ZERO_EN.
module forward_ctrl
    import fwd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [SEL_W-1:0]      op_a,
    output logic [SEL_W-1:0]      op_b
);

    fwd_slot_t        slot1_q, slot1_d;
    fwd_slot_t        slot2_q, slot2_d;
    logic [SEL_W-1:0] op_a_q, op_a_d;
    logic [SEL_W-1:0] op_b_q, op_b_d;
    logic             ex_valid_q, ex_valid_d;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             hit_a;
    logic             hit_b;
    logic             issue;

    fwd_match u_match_rs (
        .src_i      (id_rs),
        .src_used_i (id_rs_used),
        .slot1_i    (slot1_q),
        .slot2_i    (slot2_q),
        .sel_o      (sel_a),
        .load_hit_o (hit_a)
    );

    fwd_match u_match_rt (
        .src_i      (id_rt),
        .src_used_i (id_rt_used),
        .slot1_i    (slot1_q),
        .slot2_i    (slot2_q),
        .sel_o      (sel_b),
        .load_hit_o (hit_b)
    );

    assign stall = id_valid & ~flush & (hit_a | hit_b);
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        slot1_d    = '0;
        slot2_d    = slot1_q;
        op_a_d     = FWD_REG;
        op_b_d     = FWD_REG;
        ex_valid_d = 1'b0;
        if (issue) begin
            slot1_d.valid = 1'b1;
            slot1_d.rd    = id_rd;
            slot1_d.we    = id_we;
            slot1_d.load  = id_is_load;
            op_a_d        = sel_a;
            op_b_d        = sel_b;
            ex_valid_d    = 1'b1;
        end
        if (flush) begin
            slot2_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1_q    <= '0;
            slot2_q    <= '0;
            op_a_q     <= FWD_REG;
            op_b_q     <= FWD_REG;
            ex_valid_q <= 1'b0;
        end else begin
            slot1_q    <= slot1_d;
            slot2_q    <= slot2_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed self-checking bench for forward_ctrl; expectations follow FWD_R0_ZERO_EN.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [2:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    logic       ex_valid;
    logic [1:0] op_a;
    logic [1:0] op_b;

    int vectors    = 0;
    int miscompares = 0;

    forward_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .op_a       (op_a),
        .op_b       (op_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one instruction in ID: valid, rs, rs_used, rt, rt_used, rd, we, load.
    task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                         input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                         input logic we, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        #10;
        chk("reset_op_a", op_a, 2'b00);
        chk("reset_op_b", op_b, 2'b00);
        chk("reset_ex_valid", {1'b0, ex_valid}, 2'b00);
        chk("reset_stall", {1'b0, stall}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU: add r3<-r1,r2 then add r4<-r3,r1
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("b2b_first_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("b2b_first_ex_valid", {1'b0, ex_valid}, 2'b01);
        chk("b2b_first_op_a", op_a, 2'b00);
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        chk("b2b_second_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("b2b_op_a", op_a, 2'b10);
        chk("b2b_op_b", op_b, 2'b00);
        chk("b2b_ex_valid", {1'b0, ex_valid}, 2'b01);

        // Distance two: write r5, independent write r6, read r5 via rt
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0);
        tick();
        chk("dist2_op_b", op_b, 2'b01);
        chk("dist2_op_a", op_a, 2'b00);

        // Priority: r5 written by both older instructions, read on both sources
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0);
        tick();
        chk("prio_op_b", op_b, 2'b10);
        chk("prio_op_a_same_reg", op_a, 2'b10);

        // Load-use: load r2, then add r3<-r2,r1
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("lu_stall", {1'b0, stall}, 2'b01);
        tick();
        chk("lu_bubble_ex_valid", {1'b0, ex_valid}, 2'b00);
        chk("lu_bubble_op_a", op_a, 2'b00);
        chk("lu_stall_released", {1'b0, stall}, 2'b00);
        tick();
        chk("lu_op_a", op_a, 2'b01);
        chk("lu_op_b", op_b, 2'b00);
        chk("lu_ex_valid", {1'b0, ex_valid}, 2'b01);

        // Flush during stall
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("fl_stall_before", {1'b0, stall}, 2'b01);
        flush = 1'b1;
        #1;
        chk("fl_stall_forced_low", {1'b0, stall}, 2'b00);
        tick();
        flush = 1'b0;
        chk("fl_op_a", op_a, 2'b00);
        chk("fl_op_b", op_b, 2'b00);
        chk("fl_ex_valid", {1'b0, ex_valid}, 2'b00);
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        chk("fl_slots_empty_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("fl_slots_empty_op_a", op_a, 2'b00);
        chk("fl_slots_empty_op_b", op_b, 2'b00);

        // Unused sources never forward nor stall
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 3'd4, 1'b1, 1'b0);
        chk("unused_stall", {1'b0, stall}, 2'b00);
        tick();
        chk("unused_op_a", op_a, 2'b00);
        chk("unused_op_b", op_b, 2'b00);
        chk("unused_ex_valid", {1'b0, ex_valid}, 2'b01);

        // r0 destination
        drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        tick();
`ifdef FWD_R0_ZERO_EN
        chk("r0_op_a", op_a, 2'b00);
`else
        chk("r0_op_a", op_a, 2'b10);
`endif
        drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
`ifdef FWD_R0_ZERO_EN
        chk("r0_load_stall", {1'b0, stall}, 2'b00);
`else
        chk("r0_load_stall", {1'b0, stall}, 2'b01);
`endif
        tick();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();

        // Async reset during a pending forward
        drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        tick();
        chk("ar_pre_op_a", op_a, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_op_a", op_a, 2'b00);
        chk("ar_op_b", op_b, 2'b00);
        chk("ar_ex_valid", {1'b0, ex_valid}, 2'b00);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0);
        tick();
        chk("ar_after_op_a", op_a, 2'b00);
        chk("ar_after_op_b", op_b, 2'b00);
        chk("ar_after_ex_valid", {1'b0, ex_valid}, 2'b01);

        // Async reset in the middle of a stall
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        chk("ars_stall_before", {1'b0, stall}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("ars_stall_cleared", {1'b0, stall}, 2'b00);
        #2;
        rst_n = 1'b1;
        tick();
        chk("ars_issue_op_a", op_a, 2'b00);
        chk("ars_issue_ex_valid", {1'b0, ex_valid}, 2'b01);

        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
